// File: rtl/pifo_tenant_arbiter_pkg.sv
// Shared types for the PIFO tenant arbiter: tree ids, drain FSM states and pop tags.
// Latency: none (types only).
// Backpressure: not applicable.
package pifo_arb_pkg;

    localparam int TIDW_P = 2;

    typedef logic [TIDW_P-1:0] tid_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRAIN = 2'd1,
        WAIT  = 2'd2
    } drain_state_e;

    typedef struct packed {
        logic valid;
        tid_t tid;
    } pop_tag_t;

endpackage

// File: rtl/pifo_tenant_arbiter_if.sv
// Tenant request, drain control, PIFO port and response signals of the tenant arbiter.
// Latency: none (wiring only).
// Backpressure: o_req_ready is the only stall signal seen by tenants.
interface pifo_tenant_arbiter_if #(
    parameter int NTEN = 4,
    parameter int PTW  = 8,
    parameter int TIDW = 2,
    parameter int CNTW = 5
);
    logic [NTEN-1:0]      i_req_valid;
    logic [NTEN-1:0]      i_req_is_pop;
    logic [NTEN*PTW-1:0]  i_req_data;
    logic [NTEN-1:0]      o_req_ready;
    logic                 i_drain;
    logic [TIDW-1:0]      i_drain_tid;
    logic                 o_drain_busy;
    logic                 o_pifo_push;
    logic                 o_pifo_pop;
    logic [TIDW-1:0]      o_pifo_tree_id;
    logic [PTW-1:0]       o_pifo_push_data;
    logic                 i_pifo_fifo_full;
    logic [PTW-1:0]       i_pifo_pop_data;
    logic [NTEN-1:0]      o_rsp_valid;
    logic [PTW-1:0]       o_rsp_data;
    logic [NTEN*CNTW-1:0] o_occ;
`ifdef PIFO_TENANT_ARB_STATS_EN
    logic [NTEN*16-1:0]   o_stall_cnt;
`endif

    // Arbiter side
    modport slave (
        input  i_req_valid, i_req_is_pop, i_req_data, i_drain, i_drain_tid,
        input  i_pifo_fifo_full, i_pifo_pop_data,
        output o_req_ready, o_drain_busy, o_pifo_push, o_pifo_pop, o_pifo_tree_id,
        output o_pifo_push_data, o_rsp_valid, o_rsp_data, o_occ
`ifdef PIFO_TENANT_ARB_STATS_EN
        , output o_stall_cnt
`endif
    );

    // Tenant / PIFO side
    modport master (
        output i_req_valid, i_req_is_pop, i_req_data, i_drain, i_drain_tid,
        output i_pifo_fifo_full, i_pifo_pop_data,
        input  o_req_ready, o_drain_busy, o_pifo_push, o_pifo_pop, o_pifo_tree_id,
        input  o_pifo_push_data, o_rsp_valid, o_rsp_data, o_occ
`ifdef PIFO_TENANT_ARB_STATS_EN
        , input o_stall_cnt
`endif
    );

endinterface

// File: rtl/pifo_tenant_arbiter_rr_arbiter.sv
// Pointer-based round-robin arbiter: first requester at or after ptr, wrapping, one-hot grant.
// Latency: purely combinational.
// Backpressure: none; an all-zero request vector yields an all-zero grant.
module rr_arbiter #(
    parameter int N  = 4,
    parameter int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [PW-1:0] gnt_idx,
    output logic          gnt_any
);

    logic [PW-1:0] idx;

    // Scan from the pointer and take the first active request
    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        gnt_any = 1'b0;
        idx     = '0;
        for (int k = 0; k < N; k++) begin
            idx = PW'((int'(ptr) + k) % N);
            if (!gnt_any && req[idx]) begin
                gnt[idx] = 1'b1;
                gnt_idx  = idx;
                gnt_any  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/pifo_tenant_arbiter.sv
// Shares one PIFO port among NTEN tenants with quota/occupancy tracking, pop return and a drain engine; PIFO_TENANT_ARB_STATS_EN adds per-tenant stall counters.
// Latency: grant -> PIFO strobe 1 cycle; pop strobe -> tenant response POP_LAT+1 cycles.
// Backpressure: o_req_ready withheld for empty-tree pops, over-quota or fifo_full pushes, and drain-pop cycles.
module pifo_tenant_arbiter
    import pifo_arb_pkg::*;
#(
    parameter int NTEN    = 4,
    parameter int PTW     = 8,
    parameter int TIDW    = TIDW_P,
    parameter int QUOTA   = 16,
    parameter int POP_LAT = 2,
    parameter int CNTW    = $clog2(QUOTA + 1)
) (
    input logic i_clk,
    input logic i_rst,
    pifo_tenant_arbiter_if.slave bus
);

    localparam int PW = (NTEN > 1) ? $clog2(NTEN) : 1;

    logic [CNTW-1:0] occ [NTEN];
    logic [NTEN-1:0] elig;
    logic [NTEN-1:0] arb_req;
    logic [NTEN-1:0] gnt;
    logic [PW-1:0]   ptr;
    logic [PW-1:0]   gnt_idx;
    logic            gnt_any;
    drain_state_e    state;
    drain_state_e    state_nxt;
    tid_t            drain_tid;
    logic            drain_pop;
    pop_tag_t        tag_pipe [POP_LAT];
    pop_tag_t        exit_tag;
    logic            tags_busy;
    logic            iss_vld;
    logic            iss_pop;
    tid_t            iss_tid;

    // Per-tenant eligibility; the tenant being drained is masked while the drain runs
    always_comb begin
        elig = '0;
        for (int t = 0; t < NTEN; t++) begin
            if (bus.i_req_valid[t] && !(state == DRAIN && drain_tid == tid_t'(t))) begin
                if (bus.i_req_is_pop[t])
                    elig[t] = (occ[t] != '0);
                else
                    elig[t] = (occ[t] < CNTW'(QUOTA)) && !bus.i_pifo_fifo_full;
            end
        end
        arb_req = drain_pop ? '0 : elig;
    end

    rr_arbiter #(.N(NTEN), .PW(PW)) u_rr (
        .req     (arb_req),
        .ptr     (ptr),
        .gnt     (gnt),
        .gnt_idx (gnt_idx),
        .gnt_any (gnt_any)
    );

    assign bus.o_req_ready = gnt;

    // Merge drain pops (highest priority) with tenant grants into one issue slot
    always_comb begin
        iss_vld = drain_pop | gnt_any;
        iss_pop = drain_pop | (gnt_any & bus.i_req_is_pop[gnt_idx]);
        iss_tid = drain_pop ? drain_tid : tid_t'(gnt_idx);
    end

    // Round-robin pointer advances past the granted tenant, holds otherwise
    always_ff @(posedge i_clk) begin
        if (i_rst)
            ptr <= '0;
        else if (gnt_any)
            ptr <= (gnt_idx == PW'(NTEN - 1)) ? '0 : gnt_idx + 1'b1;
    end

    // Registered PIFO strobes, tree id and push data
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            bus.o_pifo_push      <= 1'b0;
            bus.o_pifo_pop       <= 1'b0;
            bus.o_pifo_tree_id   <= '0;
            bus.o_pifo_push_data <= '0;
        end else begin
            bus.o_pifo_push      <= iss_vld & ~iss_pop;
            bus.o_pifo_pop       <= iss_vld & iss_pop;
            bus.o_pifo_tree_id   <= iss_vld ? iss_tid : '0;
            bus.o_pifo_push_data <= (iss_vld && !iss_pop) ? bus.i_req_data[int'(gnt_idx)*PTW +: PTW] : '0;
        end
    end

    // Occupancy moves in the grant cycle; eligibility keeps it within [0, QUOTA]
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int t = 0; t < NTEN; t++) occ[t] <= '0;
        end else if (iss_vld) begin
            for (int t = 0; t < NTEN; t++) begin
                if (iss_tid == tid_t'(t))
                    occ[t] <= iss_pop ? occ[t] - 1'b1 : occ[t] + 1'b1;
            end
        end
    end

    // Pack occupancy counters onto the flat output
    always_comb begin
        bus.o_occ = '0;
        for (int t = 0; t < NTEN; t++) bus.o_occ[t*CNTW +: CNTW] = occ[t];
    end

    // Tag pipe follows each issued pop until its data comes back
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int i = 0; i < POP_LAT; i++) tag_pipe[i] <= '0;
        end else begin
            tag_pipe[0] <= '{valid: bus.o_pifo_pop, tid: tid_t'(bus.o_pifo_tree_id)};
            for (int i = 1; i < POP_LAT; i++) tag_pipe[i] <= tag_pipe[i-1];
        end
    end

    assign exit_tag = tag_pipe[POP_LAT-1];

    // In-flight pops include the strobe that has not yet entered the tag pipe
    always_comb begin
        tags_busy = bus.o_pifo_pop;
        for (int i = 0; i < POP_LAT; i++) tags_busy = tags_busy | tag_pipe[i].valid;
    end

    // Register returning pop data towards its owning tenant
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            bus.o_rsp_valid <= '0;
            bus.o_rsp_data  <= '0;
        end else begin
            bus.o_rsp_valid <= '0;
            bus.o_rsp_data  <= '0;
            if (exit_tag.valid) begin
                bus.o_rsp_valid[exit_tag.tid] <= 1'b1;
                bus.o_rsp_data                <= bus.i_pifo_pop_data;
            end
        end
    end

    // Drain FSM state register; the target tenant is captured only from IDLE
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state     <= IDLE;
            drain_tid <= '0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && bus.i_drain)
                drain_tid <= tid_t'(bus.i_drain_tid);
        end
    end

    // Drain FSM next state: pop until empty, then wait for outstanding responses
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (bus.i_drain) state_nxt = DRAIN;
            DRAIN:   if (occ[drain_tid] == '0) state_nxt = WAIT;
            WAIT:    if (!tags_busy) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Drain FSM outputs
    always_comb begin
        drain_pop        = (state == DRAIN) && (occ[drain_tid] != '0);
        bus.o_drain_busy = (state != IDLE);
    end

`ifdef PIFO_TENANT_ARB_STATS_EN
    logic [15:0] stall_cnt [NTEN];

    // Saturating per-tenant count of cycles spent valid but not granted
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int t = 0; t < NTEN; t++) stall_cnt[t] <= '0;
        end else begin
            for (int t = 0; t < NTEN; t++) begin
                if (bus.i_req_valid[t] && !gnt[t] && stall_cnt[t] != 16'hFFFF)
                    stall_cnt[t] <= stall_cnt[t] + 16'd1;
            end
        end
    end

    // Pack stall counters onto the flat output
    always_comb begin
        bus.o_stall_cnt = '0;
        for (int t = 0; t < NTEN; t++) bus.o_stall_cnt[t*16 +: 16] = stall_cnt[t];
    end
`endif

endmodule

// File: tb/tb_pifo_tenant_arbiter.sv
// Directed scenarios with a PIFO issue/response scoreboard for pifo_tenant_arbiter.
// Latency: checks grant->strobe of 1 cycle and strobe->response of POP_LAT+1 cycles.
// Backpressure: exercises quota, empty-pop, fifo_full and drain masking of o_req_ready.
module tb_pifo_tenant_arbiter;
    import pifo_arb_pkg::*;

    localparam int NTEN = 4, PTW = 8, TIDW = 2, QUOTA = 16, POP_LAT = 2, CNTW = 5;

    typedef struct {
        logic           is_pop;
        logic [1:0]     tid;
        logic [PTW-1:0] data;
        int             cyc;
    } iss_t;

    typedef struct {
        logic [1:0]     tid;
        logic [PTW-1:0] data;
        int             cyc;
    } rsp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   vectors = 0;
    int   miscompares = 0;
    int   pop_serial = 0;
    logic [PTW-1:0] pd0 = '0, pd1 = '0;
    iss_t exp_iss[$];
    rsp_t exp_rsp[$];

    pifo_tenant_arbiter_if #(.NTEN(NTEN), .PTW(PTW), .TIDW(TIDW), .CNTW(CNTW)) bus ();

    pifo_tenant_arbiter #(
        .NTEN(NTEN), .PTW(PTW), .TIDW(TIDW), .QUOTA(QUOTA), .POP_LAT(POP_LAT), .CNTW(CNTW)
    ) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    initial forever #5 clk = ~clk;
    initial forever begin @(posedge clk); cyc++; end

    function automatic logic [CNTW-1:0] occ_of(input int t);
        return bus.o_occ[t*CNTW +: CNTW];
    endfunction

    task automatic drv(input logic [3:0] v, input logic [3:0] p);
        bus.i_req_valid  = v;
        bus.i_req_is_pop = p;
    endtask

    task automatic exp_issue(input logic pop, input int t, input logic [PTW-1:0] d);
        iss_t e;
        e.is_pop = pop; e.tid = 2'(t); e.data = d; e.cyc = cyc + 1;
        exp_iss.push_back(e);
    endtask

    // PIFO model (pop data POP_LAT cycles after the strobe) plus issue/response scoreboard
    initial begin : monitor
        iss_t e;
        rsp_t r;
        logic [PTW-1:0] pv;
        forever begin
            @(negedge clk);
            pv = '0;
            if (bus.o_pifo_pop === 1'b1) begin
                pv = 8'h5A + 8'(pop_serial * 7);
                pop_serial++;
            end
            bus.i_pifo_pop_data = pd1;
            pd1 = pd0;
            pd0 = pv;
            if (rst) begin
                exp_iss.delete();
                exp_rsp.delete();
            end else begin
                if (bus.o_pifo_push === 1'b1 || bus.o_pifo_pop === 1'b1) begin
                    vectors++;
                    if (exp_iss.size() == 0) begin
                        miscompares++;
                        $display("FAIL issue_unexpected: push=%0b pop=%0b tid=%0d cyc=%0d, required no issue",
                                 bus.o_pifo_push, bus.o_pifo_pop, bus.o_pifo_tree_id, cyc);
                    end else begin
                        e = exp_iss.pop_front();
                        if (bus.o_pifo_pop !== e.is_pop || bus.o_pifo_push !== ~e.is_pop ||
                            bus.o_pifo_tree_id !== e.tid || bus.o_pifo_push_data !== e.data || cyc != e.cyc) begin
                            miscompares++;
                            $display("FAIL issue: got pop=%0b push=%0b tid=%0d data=%h cyc=%0d, required pop=%0b tid=%0d data=%h cyc=%0d",
                                     bus.o_pifo_pop, bus.o_pifo_push, bus.o_pifo_tree_id, bus.o_pifo_push_data, cyc,
                                     e.is_pop, e.tid, e.data, e.cyc);
                        end
                        if (e.is_pop) begin
                            r.tid = e.tid; r.data = pv; r.cyc = e.cyc + POP_LAT + 1;
                            exp_rsp.push_back(r);
                        end
                    end
                end
                if (|bus.o_rsp_valid) begin
                    vectors++;
                    if (exp_rsp.size() == 0) begin
                        miscompares++;
                        $display("FAIL rsp_unexpected: valid=%b data=%h cyc=%0d, required no response",
                                 bus.o_rsp_valid, bus.o_rsp_data, cyc);
                    end else begin
                        r = exp_rsp.pop_front();
                        if (bus.o_rsp_valid !== (4'b0001 << r.tid) || bus.o_rsp_data !== r.data || cyc != r.cyc) begin
                            miscompares++;
                            $display("FAIL rsp: got valid=%b data=%h cyc=%0d, required valid=%b data=%h cyc=%0d",
                                     bus.o_rsp_valid, bus.o_rsp_data, cyc, 4'b0001 << r.tid, r.data, r.cyc);
                        end
                    end
                end
            end
        end
    end

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1;
        drv(4'b0000, 4'b0000);
        bus.i_drain = 1'b0;
        bus.i_pifo_fifo_full = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        vectors++; if (bus.o_req_ready !== 4'b0) begin miscompares++; $display("FAIL rst_ready: got %b required 0", bus.o_req_ready); end
        vectors++; if (bus.o_pifo_push !== 1'b0) begin miscompares++; $display("FAIL rst_push: got %b required 0", bus.o_pifo_push); end
        vectors++; if (bus.o_pifo_pop !== 1'b0) begin miscompares++; $display("FAIL rst_pop: got %b required 0", bus.o_pifo_pop); end
        vectors++; if (bus.o_pifo_tree_id !== 2'b0) begin miscompares++; $display("FAIL rst_tree_id: got %0d required 0", bus.o_pifo_tree_id); end
        vectors++; if (bus.o_pifo_push_data !== 8'h0) begin miscompares++; $display("FAIL rst_push_data: got %h required 0", bus.o_pifo_push_data); end
        vectors++; if (bus.o_rsp_valid !== 4'b0) begin miscompares++; $display("FAIL rst_rsp_valid: got %b required 0", bus.o_rsp_valid); end
        vectors++; if (bus.o_rsp_data !== 8'h0) begin miscompares++; $display("FAIL rst_rsp_data: got %h required 0", bus.o_rsp_data); end
        vectors++; if (bus.o_occ !== '0) begin miscompares++; $display("FAIL rst_occ: got %h required 0", bus.o_occ); end
        vectors++; if (bus.o_drain_busy !== 1'b0) begin miscompares++; $display("FAIL rst_drain_busy: got %b required 0", bus.o_drain_busy); end
        rst = 1'b0;
    endtask

    task automatic test_back_to_back();
        for (int i = 1; i <= 3; i++) begin
            @(negedge clk);
            drv(4'b0100, 4'b0000);
            bus.i_req_data = '0;
            bus.i_req_data[2*PTW +: PTW] = 8'(i);
            #1;
            vectors++;
            if (bus.o_req_ready !== 4'b0100) begin miscompares++; $display("FAIL b2b_ready%0d: got %b required 0100", i, bus.o_req_ready); end
            exp_issue(1'b0, 2, 8'(i));
        end
        @(negedge clk); drv(4'b0000, 4'b0000);
        @(negedge clk);
        vectors++;
        if (occ_of(2) !== 5'd3) begin miscompares++; $display("FAIL b2b_occ2: got %0d required 3", occ_of(2)); end
    endtask

    task automatic test_pop_empty();
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            drv(4'b0010, 4'b0010);
            #1;
            vectors++;
            if (bus.o_req_ready !== 4'b0000) begin miscompares++; $display("FAIL pop_empty_ready: got %b required 0000", bus.o_req_ready); end
        end
        @(negedge clk); drv(4'b0000, 4'b0000);
        @(negedge clk);
    endtask

    task automatic test_round_robin();
        int g[6] = '{0, 1, 3, 0, 1, 3};
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            drv(4'b1011, 4'b0000);
            for (int t = 0; t < NTEN; t++) bus.i_req_data[t*PTW +: PTW] = 8'(16*t + i);
            #1;
            vectors++;
            if (bus.o_req_ready !== (4'b0001 << g[i])) begin
                miscompares++;
                $display("FAIL rr_grant%0d: got %b required %b", i, bus.o_req_ready, 4'b0001 << g[i]);
            end
            exp_issue(1'b0, g[i], 8'(16*g[i] + i));
        end
        @(negedge clk); drv(4'b0000, 4'b0000);
        @(negedge clk);
        for (int t = 0; t < NTEN; t++) begin
            vectors++;
            if (occ_of(t) !== ((t == 2) ? 5'd0 : 5'd2)) begin
                miscompares++;
                $display("FAIL rr_occ%0d: got %0d required %0d", t, occ_of(t), (t == 2) ? 0 : 2);
            end
        end
    endtask

    task automatic test_quota();
        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            drv(4'b0001, 4'b0000);
            bus.i_req_data[0 +: PTW] = 8'h80 + 8'(i);
            #1;
            vectors++;
            if (bus.o_req_ready !== 4'b0001) begin miscompares++; $display("FAIL quota_fill%0d: got %b required 0001", i, bus.o_req_ready); end
            exp_issue(1'b0, 0, 8'h80 + 8'(i));
        end
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            drv(4'b0001, 4'b0000);
            #1;
            vectors++;
            if (bus.o_req_ready !== 4'b0000) begin miscompares++; $display("FAIL quota_block: got %b required 0000 (occ=%0d)", bus.o_req_ready, occ_of(0)); end
        end
        vectors++;
        if (occ_of(0) !== 5'd16) begin miscompares++; $display("FAIL quota_occ_full: got %0d required 16", occ_of(0)); end
        @(negedge clk);
        drv(4'b0001, 4'b0001);
        #1;
        vectors++;
        if (bus.o_req_ready !== 4'b0001) begin miscompares++; $display("FAIL quota_pop: got %b required 0001", bus.o_req_ready); end
        exp_issue(1'b1, 0, 8'h00);
        @(negedge clk);
        drv(4'b0001, 4'b0000);
        bus.i_req_data[0 +: PTW] = 8'hEE;
        #1;
        vectors++;
        if (bus.o_req_ready !== 4'b0001) begin miscompares++; $display("FAIL quota_push_after_pop: got %b required 0001", bus.o_req_ready); end
        exp_issue(1'b0, 0, 8'hEE);
        @(negedge clk);
        drv(4'b0001, 4'b0001);
        #1;
        exp_issue(1'b1, 0, 8'h00);
        @(negedge clk); drv(4'b0000, 4'b0000);
        vectors++;
        if (occ_of(0) !== 5'd15) begin miscompares++; $display("FAIL quota_occ_after: got %0d required 15", occ_of(0)); end
    endtask

    task automatic test_fifo_full();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            drv(4'b0100, 4'b0000);
            bus.i_req_data[2*PTW +: PTW] = 8'h20 + 8'(i);
            #1;
            exp_issue(1'b0, 2, 8'h20 + 8'(i));
        end
        @(negedge clk);
        bus.i_pifo_fifo_full = 1'b1;
        drv(4'b0101, 4'b0100);
        bus.i_req_data[0 +: PTW] = 8'h33;
        #1;
        vectors++;
        if (bus.o_req_ready !== 4'b0100) begin miscompares++; $display("FAIL full_pop_only: got %b required 0100", bus.o_req_ready); end
        exp_issue(1'b1, 2, 8'h00);
        @(negedge clk);
        drv(4'b0001, 4'b0000);
        #1;
        vectors++;
        if (bus.o_req_ready !== 4'b0000) begin miscompares++; $display("FAIL full_push_blocked: got %b required 0000", bus.o_req_ready); end
        @(negedge clk);
        bus.i_pifo_fifo_full = 1'b0;
        #1;
        vectors++;
        if (bus.o_req_ready !== 4'b0001) begin miscompares++; $display("FAIL full_release: got %b required 0001", bus.o_req_ready); end
        exp_issue(1'b0, 0, 8'h33);
        @(negedge clk); drv(4'b0000, 4'b0000);
        repeat (4) @(negedge clk);
    endtask

    task automatic test_drain();
        @(negedge clk);
        bus.i_drain = 1'b1;
        bus.i_drain_tid = 2'd2;
        #1;
        vectors++;
        if (bus.o_drain_busy !== 1'b0) begin miscompares++; $display("FAIL drain_busy_start: got %b required 0", bus.o_drain_busy); end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            bus.i_drain = 1'b0;
            drv(4'b0110, 4'b0100);
            bus.i_req_data[1*PTW +: PTW] = 8'h77;
            #1;
            vectors++;
            if (bus.o_req_ready !== 4'b0000 || bus.o_drain_busy !== 1'b1) begin
                miscompares++;
                $display("FAIL drain_pop%0d: got ready=%b busy=%b required ready=0000 busy=1", i, bus.o_req_ready, bus.o_drain_busy);
            end
            exp_issue(1'b1, 2, 8'h00);
        end
        @(negedge clk);
        #1;
        vectors++;
        if (bus.o_req_ready !== 4'b0010) begin miscompares++; $display("FAIL drain_other_tenant: got %b required 0010", bus.o_req_ready); end
        exp_issue(1'b0, 1, 8'h77);
        @(negedge clk); drv(4'b0000, 4'b0000);
        repeat (2) @(negedge clk);
        #1;
        vectors++;
        if (bus.o_drain_busy !== 1'b1) begin miscompares++; $display("FAIL drain_busy_last_rsp: got %b required 1", bus.o_drain_busy); end
        @(negedge clk);
        #1;
        vectors++;
        if (bus.o_drain_busy !== 1'b0) begin miscompares++; $display("FAIL drain_busy_end: got %b required 0", bus.o_drain_busy); end
        vectors++;
        if (occ_of(2) !== 5'd0 || occ_of(1) !== 5'd3) begin
            miscompares++;
            $display("FAIL drain_occ: got occ2=%0d occ1=%0d required occ2=0 occ1=3", occ_of(2), occ_of(1));
        end
    endtask

    task automatic test_reset_inflight();
        int seen = 0;
        @(negedge clk);
        drv(4'b1000, 4'b1000);
        #1;
        vectors++;
        if (bus.o_req_ready !== 4'b1000) begin miscompares++; $display("FAIL inflight_pop: got %b required 1000", bus.o_req_ready); end
        exp_issue(1'b1, 3, 8'h00);
        @(negedge clk);
        drv(4'b0000, 4'b0000);
        rst = 1'b1;
        @(negedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (|bus.o_rsp_valid) seen++;
        end
        vectors++;
        if (seen != 0) begin miscompares++; $display("FAIL inflight_rsp_dropped: got %0d responses required 0", seen); end
        vectors++;
        if (occ_of(3) !== 5'd0) begin miscompares++; $display("FAIL inflight_occ3: got %0d required 0", occ_of(3)); end
    endtask

    initial begin
        bus.i_req_valid      = '0;
        bus.i_req_is_pop     = '0;
        bus.i_req_data       = '0;
        bus.i_drain          = 1'b0;
        bus.i_drain_tid      = '0;
        bus.i_pifo_fifo_full = 1'b0;
        bus.i_pifo_pop_data  = '0;

        test_reset();
        test_back_to_back();
        test_pop_empty();
        test_reset();
        test_round_robin();
        test_quota();
        test_fifo_full();
        test_drain();
        test_reset_inflight();

        repeat (2) @(negedge clk);
        vectors++;
        if (exp_iss.size() != 0 || exp_rsp.size() != 0) begin
            miscompares++;
            $display("FAIL scoreboard_drained: got %0d issues %0d responses outstanding, required 0", exp_iss.size(), exp_rsp.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
